// File: rtl/regfile_sb.sv
// Two-read/one-write register file with write-through bypass and a pending-write
// scoreboard that the controller uses to stall on read-after-write hazards.
module regfile_sb #(
    parameter int DW      = 8,
    parameter int NREG    = 4,
    parameter int AW      = 2,
    parameter bit ZERO_R0 = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] ra,
    input  logic [AW-1:0] rb,
    output logic [DW-1:0] reg_data1,
    output logic [DW-1:0] reg_data2,
    input  logic          reg_en,
    input  logic [AW-1:0] wb,
    input  logic [DW-1:0] data,
    input  logic          iss_en,
    input  logic [AW-1:0] iss_addr,
    output logic          busy_a,
    output logic          busy_b,
    output logic [AW:0]   pend_cnt,
    output logic          wb_err
);

    logic [DW-1:0]   r_mem [NREG];
    logic [NREG-1:0] r_busy;
    logic [AW:0]     r_pend_cnt;
    logic            r_wb_err;

    logic [NREG-1:0] w_busy_nxt;
    logic [AW:0]     w_busy_pop;
    logic            w_wr_live;
    logic            w_byp_a;
    logic            w_byp_b;

    // A write aimed at a hardwired-zero R0 is dropped entirely, including its error check.
    assign w_wr_live = reg_en && !(ZERO_R0 && (wb == '0));

    // Issue beats writeback so a new producer keeps the register pending.
    always_comb begin
        w_busy_nxt = r_busy;
        w_busy_pop = '0;
        for (int i = 0; i < NREG; i++) begin
            if (iss_en && (iss_addr == AW'(i)) && !(ZERO_R0 && (i == 0))) begin
                w_busy_nxt[i] = 1'b1;
            end else if (reg_en && (wb == AW'(i))) begin
                w_busy_nxt[i] = 1'b0;
            end
            w_busy_pop = w_busy_pop + (AW+1)'(w_busy_nxt[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
            r_busy     <= '0;
            r_pend_cnt <= '0;
            r_wb_err   <= 1'b0;
        end else begin
            if (w_wr_live) begin
                r_mem[wb] <= data;
            end
            if (w_wr_live && !r_busy[wb]) begin
                r_wb_err <= 1'b1;
            end
            r_busy     <= w_busy_nxt;
            r_pend_cnt <= w_busy_pop;
        end
    end

    // Bypass is suppressed during reset so reads show the stored contents.
    assign w_byp_a = reg_en && !rst && (wb == ra);
    assign w_byp_b = reg_en && !rst && (wb == rb);

    assign reg_data1 = (ZERO_R0 && (ra == '0)) ? '0 : (w_byp_a ? data : r_mem[ra]);
    assign reg_data2 = (ZERO_R0 && (rb == '0)) ? '0 : (w_byp_b ? data : r_mem[rb]);

    assign busy_a   = r_busy[ra] && !(reg_en && (wb == ra));
    assign busy_b   = r_busy[rb] && !(reg_en && (wb == rb));
    assign pend_cnt = r_pend_cnt;
    assign wb_err   = r_wb_err;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: default, hardwired-zero R0 and 16x16 variants.
module tb_regfile_sb;

    logic clk = 1'b0;
    logic rst;

    // Shared stimulus for the two 4x8 instances
    logic [1:0] ra, rb, wb, issAddr;
    logic [7:0] data;
    logic       regEn, issEn;

    logic [7:0] aData1, aData2, zData1, zData2;
    logic       aBusyA, aBusyB, zBusyA, zBusyB, aWbErr, zWbErr;
    logic [2:0] aPend, zPend;

    // Stimulus and outputs of the 16x16 instance
    logic [3:0]  wRa, wRb, wWb, wIssAddr;
    logic [15:0] wData, wData1, wData2;
    logic        wRegEn, wIssEn, wBusyA, wBusyB, wWbErr;
    logic [4:0]  wPend;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_sb dutA (
        .clk(clk), .rst(rst), .ra(ra), .rb(rb),
        .reg_data1(aData1), .reg_data2(aData2),
        .reg_en(regEn), .wb(wb), .data(data),
        .iss_en(issEn), .iss_addr(issAddr),
        .busy_a(aBusyA), .busy_b(aBusyB), .pend_cnt(aPend), .wb_err(aWbErr)
    );

    regfile_sb #(.ZERO_R0(1'b1)) dutZ (
        .clk(clk), .rst(rst), .ra(ra), .rb(rb),
        .reg_data1(zData1), .reg_data2(zData2),
        .reg_en(regEn), .wb(wb), .data(data),
        .iss_en(issEn), .iss_addr(issAddr),
        .busy_a(zBusyA), .busy_b(zBusyB), .pend_cnt(zPend), .wb_err(zWbErr)
    );

    regfile_sb #(.DW(16), .NREG(16), .AW(4)) dutW (
        .clk(clk), .rst(rst), .ra(wRa), .rb(wRb),
        .reg_data1(wData1), .reg_data2(wData2),
        .reg_en(wRegEn), .wb(wWb), .data(wData),
        .iss_en(wIssEn), .iss_addr(wIssAddr),
        .busy_a(wBusyA), .busy_b(wBusyB), .pend_cnt(wPend), .wb_err(wWbErr)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic en, input logic [1:0] addr, input logic [7:0] d,
                                 input logic iss, input logic [1:0] ia);
        regEn   = en;
        wb      = addr;
        data    = d;
        issEn   = iss;
        issAddr = ia;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        ra = 2'd1; rb = 2'd0;
        applyStimulus(1'b1, 2'd1, 8'h33, 1'b1, 2'd1);
        wRa = '0; wRb = '0; wWb = '0; wIssAddr = '0; wData = '0; wRegEn = 1'b0; wIssEn = 1'b0;

        // Reset edge with a write and issue pending: bypass off, nothing lands
        tick();
        checkOutput("rst_no_bypass", 32'(aData1), 32'h0);
        tick();
        rst = 1'b0;
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 2'd0);
        checkOutput("rst_write_blocked", 32'(aData1), 32'h0);
        checkOutput("rst_pend", 32'(aPend), 32'h0);
        checkOutput("rst_wb_err", 32'(aWbErr), 32'h0);
        for (int i = 0; i < 4; i++) begin
            ra = 2'(i);
            #1;
            checkOutput($sformatf("rst_data_r%0d", i), 32'(aData1), 32'h0);
            checkOutput($sformatf("rst_busy_r%0d", i), 32'(aBusyA), 32'h0);
        end

        // Issue R2, then write it back with bypass
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 2'd2);
        tick();
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 2'd0);
        ra = 2'd2; rb = 2'd2;
        #1;
        checkOutput("r2_pend", 32'(aPend), 32'h1);
        checkOutput("r2_busy_before_wb", 32'(aBusyA), 32'h1);
        applyStimulus(1'b1, 2'd2, 8'hFB, 1'b0, 2'd0);
        checkOutput("r2_bypass_a", 32'(aData1), 32'hFB);
        checkOutput("r2_bypass_b", 32'(aData2), 32'hFB);
        checkOutput("r2_busy_a_masked", 32'(aBusyA), 32'h0);
        checkOutput("r2_busy_b_masked", 32'(aBusyB), 32'h0);
        tick();
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 2'd0);
        checkOutput("r2_stored", 32'(aData1), 32'hFB);
        checkOutput("r2_pend_after", 32'(aPend), 32'h0);
        checkOutput("r2_no_err", 32'(aWbErr), 32'h0);

        // Two issues, then simultaneous issue+writeback on R1
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 2'd1);
        tick();
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 2'd3);
        tick();
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 2'd0);
        checkOutput("two_pend", 32'(aPend), 32'h2);
        applyStimulus(1'b1, 2'd1, 8'h07, 1'b1, 2'd1);
        tick();
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 2'd0);
        ra = 2'd1; rb = 2'd3;
        #1;
        checkOutput("set_wins_data", 32'(aData1), 32'h07);
        checkOutput("set_wins_busy", 32'(aBusyA), 32'h1);
        checkOutput("set_wins_pend", 32'(aPend), 32'h2);
        checkOutput("set_wins_no_err", 32'(aWbErr), 32'h0);
        applyStimulus(1'b1, 2'd1, 8'h09, 1'b0, 2'd0);
        tick();
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 2'd0);
        checkOutput("r1_clear_busy", 32'(aBusyA), 32'h0);
        checkOutput("r1_clear_pend", 32'(aPend), 32'h1);
        checkOutput("r1_data", 32'(aData1), 32'h09);
        checkOutput("r3_still_busy", 32'(aBusyB), 32'h1);

        // Clear R3 legitimately, then write it again while idle -> sticky error
        applyStimulus(1'b1, 2'd3, 8'h05, 1'b0, 2'd0);
        tick();
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 2'd0);
        checkOutput("r3_clear_no_err", 32'(aWbErr), 32'h0);
        checkOutput("r3_clear_pend", 32'(aPend), 32'h0);
        applyStimulus(1'b1, 2'd3, 8'h0C, 1'b0, 2'd0);
        tick();
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 2'd0);
        ra = 2'd3;
        #1;
        checkOutput("wb_err_set", 32'(aWbErr), 32'h1);
        checkOutput("wb_err_write_done", 32'(aData1), 32'h0C);
        tick();
        checkOutput("wb_err_sticky", 32'(aWbErr), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checkOutput("wb_err_rst", 32'(aWbErr), 32'h0);
        checkOutput("rst_clears_r3", 32'(aData1), 32'h0);
        ra = 2'd2;
        #1;
        checkOutput("rst_clears_r2", 32'(aData1), 32'h0);

        // R0 write+issue: hardwired zero on dutZ, ordinary register on dutA
        ra = 2'd0;
        applyStimulus(1'b1, 2'd0, 8'h55, 1'b1, 2'd0);
        checkOutput("z_r0_read_bypass", 32'(zData1), 32'h0);
        checkOutput("a_r0_bypass", 32'(aData1), 32'h55);
        tick();
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 2'd0);
        checkOutput("z_r0_data", 32'(zData1), 32'h0);
        checkOutput("z_r0_busy", 32'(zBusyA), 32'h0);
        checkOutput("z_r0_pend", 32'(zPend), 32'h0);
        checkOutput("z_r0_no_err", 32'(zWbErr), 32'h0);
        checkOutput("a_r0_data", 32'(aData1), 32'h55);
        checkOutput("a_r0_busy", 32'(aBusyA), 32'h1);
        checkOutput("a_r0_pend", 32'(aPend), 32'h1);
        checkOutput("a_r0_err", 32'(aWbErr), 32'h1);

        // 16x16: fill the scoreboard to its full count, then retire R15
        for (int i = 0; i < 16; i++) begin
            wIssEn = 1'b1;
            wIssAddr = 4'(i);
            tick();
        end
        wIssEn = 1'b0;
        #1;
        checkOutput("w_pend_full", 32'(wPend), 32'd16);
        wRa = 4'd15; wRb = 4'd15; wWb = 4'd15; wData = 16'h8001; wRegEn = 1'b1;
        #1;
        checkOutput("w_bypass_a", 32'(wData1), 32'h8001);
        checkOutput("w_bypass_b", 32'(wData2), 32'h8001);
        checkOutput("w_busy_a_masked", 32'(wBusyA), 32'h0);
        checkOutput("w_busy_b_masked", 32'(wBusyB), 32'h0);
        tick();
        wRegEn = 1'b0;
        wRb = 4'd0;
        #1;
        checkOutput("w_pend_15", 32'(wPend), 32'd15);
        checkOutput("w_no_err", 32'(wWbErr), 32'h0);
        checkOutput("w_r15_stored", 32'(wData1), 32'h8001);
        checkOutput("w_r0_busy", 32'(wBusyB), 32'h1);
        wData = 16'h1234; wRegEn = 1'b1;
        tick();
        wRegEn = 1'b0;
        #1;
        checkOutput("w_err_set", 32'(wWbErr), 32'h1);
        checkOutput("w_r15_rewritten", 32'(wData1), 32'h1234);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
